mem_arbiter: RTL and testbench

- Shares NUM_CHANNELS external memory channels among NUM_CONSUMERS LSU requesters.
- Requesters are the per-thread LSUs of one or more cores, each with its own read and write ports.
- Arbitration is round-robin; each channel runs its own transaction FSM.
- Sits between the cores' LSU valid/ready interfaces and the data-memory ports.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_channel.sv | 91 +++++++++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the LSU-to-memory arbiter: channel FSM encoding and
// the consumer index width helper.
package mem_arbiter_pkg;

    localparam int STATE_BITS = 3;

    typedef logic [STATE_BITS-1:0] ch_state_t;

    localparam ch_state_t ST_IDLE           = 3'd0;
    localparam ch_state_t ST_READ_WAITING   = 3'd1;
    localparam ch_state_t ST_WRITE_WAITING  = 3'd2;
    localparam ch_state_t ST_READ_RELAYING  = 3'd3;
    localparam ch_state_t ST_WRITE_RELAYING = 3'd4;

    // Index width for n consumers; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/mem_channel.sv
// One memory channel: owns a single consumer transaction from grant through
// the memory handshake until the consumer releases its valid.
module mem_channel
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int IDX_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_grant,
    input  logic [IDX_BITS-1:0]   i_grant_index,
    input  logic                  i_grant_is_write,
    input  logic [ADDR_BITS-1:0]  i_grant_address,
    input  logic [DATA_BITS-1:0]  i_grant_data,
    input  logic                  i_owner_read_valid,
    input  logic                  i_owner_write_valid,
    input  logic                  i_mem_read_ready,
    input  logic                  i_mem_write_ready,
    output logic                  o_mem_read_valid,
    output logic                  o_mem_write_valid,
    output logic [ADDR_BITS-1:0]  o_mem_address,
    output logic [DATA_BITS-1:0]  o_mem_write_data,
    output logic [IDX_BITS-1:0]   o_owner,
    output logic                  o_read_ready,
    output logic                  o_write_ready,
    output logic                  o_read_capture,
    output logic                  o_release,
    output logic                  o_idle,
    output logic [STATE_BITS-1:0] o_state
);

    ch_state_t             r_state;
    ch_state_t             w_next_state;
    logic [IDX_BITS-1:0]   r_owner;
    logic [ADDR_BITS-1:0]  r_address;
    logic [DATA_BITS-1:0]  r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:           if (i_grant) w_next_state = i_grant_is_write ? ST_WRITE_WAITING
                                                                            : ST_READ_WAITING;
            ST_READ_WAITING:   if (i_mem_read_ready)     w_next_state = ST_READ_RELAYING;
            ST_WRITE_WAITING:  if (i_mem_write_ready)    w_next_state = ST_WRITE_RELAYING;
            ST_READ_RELAYING:  if (!i_owner_read_valid)  w_next_state = ST_IDLE;
            ST_WRITE_RELAYING: if (!i_owner_write_valid) w_next_state = ST_IDLE;
            default:           w_next_state = ST_IDLE;
        endcase
    end

    // Valid/ready: a request stays valid until its ready is seen; ready is held
    // toward the consumer until that consumer's valid falls, which frees the channel.
    always_comb begin
        o_mem_read_valid  = (r_state == ST_READ_WAITING);
        o_mem_write_valid = (r_state == ST_WRITE_WAITING);
        o_read_ready      = (r_state == ST_READ_RELAYING);
        o_write_ready     = (r_state == ST_WRITE_RELAYING);
        o_read_capture    = (r_state == ST_READ_WAITING) && i_mem_read_ready;
        o_release         = ((r_state == ST_READ_RELAYING)  && !i_owner_read_valid) ||
                            ((r_state == ST_WRITE_RELAYING) && !i_owner_write_valid);
        o_idle            = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner   <= '0;
            r_address <= '0;
            r_data    <= '0;
        end else if ((r_state == ST_IDLE) && i_grant) begin
            r_owner   <= i_grant_index;
            r_address <= i_grant_address;
            r_data    <= i_grant_data;
        end
    end

    assign o_mem_address    = r_address;
    assign o_mem_write_data = r_data;
    assign o_owner          = r_owner;
    assign o_state          = r_state;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS memory channels among NUM_CONSUMERS
// LSU read/write requesters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int IDX_BITS = clog2(NUM_CONSUMERS);

    logic [IDX_BITS-1:0]      r_rr_ptr;
    logic [NUM_CONSUMERS-1:0] r_claimed;
    logic [DATA_BITS-1:0]     r_read_data [NUM_CONSUMERS];

    logic [ADDR_BITS-1:0]     w_rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     w_wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     w_wr_data [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] w_eligible;
    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [NUM_CONSUMERS-1:0] w_clr_mask;
    logic [IDX_BITS:0]        w_sum;
    logic [IDX_BITS-1:0]      w_scan;
    logic                     w_any_grant;
    logic [IDX_BITS-1:0]      w_last_index;

    logic                     w_grant          [NUM_CHANNELS];
    logic [IDX_BITS-1:0]      w_grant_index    [NUM_CHANNELS];
    logic                     w_grant_is_write [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     w_grant_address  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     w_grant_data     [NUM_CHANNELS];
    logic                     w_idle           [NUM_CHANNELS];
    logic [IDX_BITS-1:0]      w_owner          [NUM_CHANNELS];
    logic                     w_read_ready     [NUM_CHANNELS];
    logic                     w_write_ready    [NUM_CHANNELS];
    logic                     w_read_capture   [NUM_CHANNELS];
    logic                     w_release        [NUM_CHANNELS];

    genvar c, ch;
    generate
        for (c = 0; c < NUM_CONSUMERS; c++) begin : g_cons
            assign w_rd_addr[c] = consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
            assign w_wr_addr[c] = consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
            assign w_wr_data[c] = consumer_write_data[c*DATA_BITS +: DATA_BITS];
            assign consumer_read_data[c*DATA_BITS +: DATA_BITS] = r_read_data[c];
        end
    endgenerate

    assign w_eligible = (consumer_read_valid | consumer_write_valid) & ~r_claimed;

    // Channels pick in index order; w_taken hides a consumer from later channels.
    always_comb begin
        w_taken      = '0;
        w_sum        = '0;
        w_scan       = '0;
        w_any_grant  = 1'b0;
        w_last_index = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            w_grant[k]          = 1'b0;
            w_grant_index[k]    = '0;
            w_grant_is_write[k] = 1'b0;
            w_grant_address[k]  = '0;
            w_grant_data[k]     = '0;
            if (w_idle[k]) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    w_sum = {1'b0, r_rr_ptr} + (IDX_BITS+1)'(i);
                    if (w_sum >= (IDX_BITS+1)'(NUM_CONSUMERS))
                        w_sum = w_sum - (IDX_BITS+1)'(NUM_CONSUMERS);
                    w_scan = w_sum[IDX_BITS-1:0];
                    if (!w_grant[k] && w_eligible[w_scan] && !w_taken[w_scan]) begin
                        w_grant[k]          = 1'b1;
                        w_grant_index[k]    = w_scan;
                        w_grant_is_write[k] = !consumer_read_valid[w_scan];
                        w_grant_address[k]  = consumer_read_valid[w_scan] ? w_rd_addr[w_scan]
                                                                          : w_wr_addr[w_scan];
                        w_grant_data[k]     = w_wr_data[w_scan];
                    end
                end
            end
            if (w_grant[k]) begin
                w_taken[w_grant_index[k]] = 1'b1;
                w_any_grant               = 1'b1;
                w_last_index              = w_grant_index[k];
            end
        end
    end

    always_comb begin
        w_clr_mask           = '0;
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_release[k])     w_clr_mask[w_owner[k]]           = 1'b1;
            if (w_read_ready[k])  consumer_read_ready[w_owner[k]]  = 1'b1;
            if (w_write_ready[k]) consumer_write_ready[w_owner[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr  <= '0;
            r_claimed <= '0;
        end else begin
            r_claimed <= (r_claimed | w_taken) & ~w_clr_mask;
            if (w_any_grant)
                r_rr_ptr <= (w_last_index == IDX_BITS'(NUM_CONSUMERS-1)) ? '0
                                                                         : w_last_index + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) r_read_data[i] <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++)
                if (w_read_capture[k])
                    r_read_data[w_owner[k]] <= mem_read_data[k*DATA_BITS +: DATA_BITS];
        end
    end

    generate
        for (ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
            logic [ADDR_BITS-1:0]  w_mem_address;
            logic [STATE_BITS-1:0] w_state;
            logic                  w_owner_rv;
            logic                  w_owner_wv;

            assign w_owner_rv = consumer_read_valid[w_owner[ch]];
            assign w_owner_wv = consumer_write_valid[w_owner[ch]];
            assign mem_read_address[ch*ADDR_BITS +: ADDR_BITS]  = w_mem_address;
            assign mem_write_address[ch*ADDR_BITS +: ADDR_BITS] = w_mem_address;

            mem_channel #(
                .ADDR_BITS (ADDR_BITS),
                .DATA_BITS (DATA_BITS),
                .IDX_BITS  (IDX_BITS)
            ) u_channel (
                .clk                 (clk),
                .reset               (reset),
                .i_grant             (w_grant[ch]),
                .i_grant_index       (w_grant_index[ch]),
                .i_grant_is_write    (w_grant_is_write[ch]),
                .i_grant_address     (w_grant_address[ch]),
                .i_grant_data        (w_grant_data[ch]),
                .i_owner_read_valid  (w_owner_rv),
                .i_owner_write_valid (w_owner_wv),
                .i_mem_read_ready    (mem_read_ready[ch]),
                .i_mem_write_ready   (mem_write_ready[ch]),
                .o_mem_read_valid    (mem_read_valid[ch]),
                .o_mem_write_valid   (mem_write_valid[ch]),
                .o_mem_address       (w_mem_address),
                .o_mem_write_data    (mem_write_data[ch*DATA_BITS +: DATA_BITS]),
                .o_owner             (w_owner[ch]),
                .o_read_ready        (w_read_ready[ch]),
                .o_write_ready       (w_write_ready[ch]),
                .o_read_capture      (w_read_capture[ch]),
                .o_release           (w_release[ch]),
                .o_idle              (w_idle[ch]),
                .o_state             (w_state)
            );
        end
    endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one single-channel and one dual-channel instance.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;

    logic [3:0]  rv, wv, rd_ready, wr_ready;
    logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
    logic [0:0]  m_rv, m_rr, m_wv, m_wr;
    logic [7:0]  m_raddr, m_rdata, m_waddr, m_wdata;
    logic        auto_mem;
    logic        man_rr;
    logic [7:0]  man_rdata;

    logic [3:0]  d2_rv, d2_rd_ready, d2_wr_ready;
    logic [31:0] d2_rd_data;
    logic [1:0]  d2_m_rv, d2_m_rr, d2_m_wv;
    logic [15:0] d2_m_raddr, d2_m_rdata, d2_m_waddr, d2_m_wdata;

    int n_checks;
    int n_errors;

    assign m_rr[0] = auto_mem ? m_rv[0] : man_rr;
    assign m_rdata = auto_mem ? ~m_raddr : man_rdata;

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (rd_addr),
        .consumer_read_ready    (rd_ready),
        .consumer_read_data     (rd_data),
        .consumer_write_valid   (wv),
        .consumer_write_address (wr_addr),
        .consumer_write_data    (wr_data),
        .consumer_write_ready   (wr_ready),
        .mem_read_valid         (m_rv),
        .mem_read_address       (m_raddr),
        .mem_read_ready         (m_rr),
        .mem_read_data          (m_rdata),
        .mem_write_valid        (m_wv),
        .mem_write_address      (m_waddr),
        .mem_write_data         (m_wdata),
        .mem_write_ready        (m_wr)
    );

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (d2_rv),
        .consumer_read_address  (32'h2322_2120),
        .consumer_read_ready    (d2_rd_ready),
        .consumer_read_data     (d2_rd_data),
        .consumer_write_valid   (4'b0000),
        .consumer_write_address (32'h0),
        .consumer_write_data    (32'h0),
        .consumer_write_ready   (d2_wr_ready),
        .mem_read_valid         (d2_m_rv),
        .mem_read_address       (d2_m_raddr),
        .mem_read_ready         (d2_m_rr),
        .mem_read_data          (d2_m_rdata),
        .mem_write_valid        (d2_m_wv),
        .mem_write_address      (d2_m_waddr),
        .mem_write_data         (d2_m_wdata),
        .mem_write_ready        (2'b00)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] v, input int idx);
        return 8'(v >> (idx * 8));
    endfunction

    task automatic do_reset();
        rv = '0; wv = '0; d2_rv = '0;
        auto_mem = 1'b0; man_rr = 1'b0; man_rdata = '0; m_wr = '0; d2_m_rr = '0;
        d2_m_rdata = '0;
        rd_addr = 32'h1312_1110; wr_addr = 32'h0; wr_data = 32'h0;
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        int wait_n;
        n_checks = 0;
        n_errors = 0;

        // Reset with every consumer requesting: outputs held at zero.
        do_reset();
        reset = 1'b0;
        rv = 4'hF;
        cyc();
        check("rst_mem_rv", 32'(m_rv), 32'h0);
        check("rst_mem_addr", 32'(m_raddr), 32'h0);
        check("rst_cons_ready", 32'(rd_ready), 32'h0);
        check("rst_cons_data", rd_data, 32'h0);
        check("rst_mem_wv", 32'(m_wv), 32'h0);
        reset = 1'b1;
        cyc();
        check("rst_first_rv", 32'(m_rv), 32'h1);
        check("rst_first_addr", 32'(m_raddr), 32'h10);

        // Single read: consumer 2 reads 0x3C, memory answers 0xA5 a cycle later.
        do_reset();
        rd_addr[23:16] = 8'h3C;
        rv = 4'b0100;
        cyc();
        check("rd_mem_rv", 32'(m_rv), 32'h1);
        check("rd_mem_addr", 32'(m_raddr), 32'h3C);
        cyc();
        check("rd_wait_ready", 32'(rd_ready), 32'h0);
        man_rr = 1'b1; man_rdata = 8'hA5;
        cyc();
        man_rr = 1'b0; man_rdata = 8'h00;
        check("rd_ready", 32'(rd_ready), 32'h4);
        check("rd_data", 32'(byte_of(rd_data, 2)), 32'hA5);
        check("rd_mem_rv_drop", 32'(m_rv), 32'h0);
        cyc();
        check("rd_ready_hold", 32'(rd_ready), 32'h4);
        rv = 4'b0000;
        cyc();
        check("rd_ready_fall", 32'(rd_ready), 32'h0);
        check("rd_data_hold", 32'(byte_of(rd_data, 2)), 32'hA5);
        rv = 4'b0100;
        cyc();
        check("rd_regrant", 32'(m_rv), 32'h1);

        // Round robin on one channel with a one-cycle memory.
        do_reset();
        auto_mem = 1'b1;
        rv = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int exp_c;
            exp_c = k % 4;
            wait_n = 0;
            while (m_rv[0] !== 1'b1 && wait_n < 10) begin
                cyc();
                wait_n++;
            end
            check($sformatf("rr_valid_%0d", k), 32'(m_rv), 32'h1);
            check($sformatf("rr_addr_%0d", k), 32'(m_raddr), 32'h10 + 32'(exp_c));
            cyc();
            check($sformatf("rr_ready_%0d", k), 32'(rd_ready), 32'h1 << exp_c);
            check($sformatf("rr_data_%0d", k), 32'(byte_of(rd_data, exp_c)), 32'(8'hEF - 8'(exp_c)));
            rv[exp_c] = 1'b0;
            cyc();
            if (k < 4) rv[exp_c] = 1'b1;
            else rv = 4'h0;
        end
        auto_mem = 1'b0;
        cyc();

        // Read wins over write when a consumer asserts both.
        do_reset();
        wr_addr = 32'h0000_9900;
        rv = 4'b0010; wv = 4'b0010;
        cyc();
        check("both_rv", 32'(m_rv), 32'h1);
        check("both_wv", 32'(m_wv), 32'h0);
        check("both_addr", 32'(m_raddr), 32'h11);
        man_rr = 1'b1; man_rdata = 8'h5A;
        cyc();
        man_rr = 1'b0;
        check("both_rd_ready", 32'(rd_ready), 32'h2);
        check("both_wr_ready", 32'(wr_ready), 32'h0);
        rv = '0; wv = '0;
        cyc();

        // Write: consumer 0 writes 0x7E to 0x10.
        do_reset();
        wr_addr = 32'h0000_0010; wr_data = 32'h0000_007E;
        wv = 4'b0001;
        cyc();
        check("wr_mem_wv", 32'(m_wv), 32'h1);
        check("wr_mem_addr", 32'(m_waddr), 32'h10);
        check("wr_mem_data", 32'(m_wdata), 32'h7E);
        check("wr_mem_rv", 32'(m_rv), 32'h0);
        cyc();
        check("wr_wait_ready", 32'(wr_ready), 32'h0);
        m_wr = 1'b1;
        cyc();
        m_wr = 1'b0;
        check("wr_ready", 32'(wr_ready), 32'h1);
        check("wr_mem_wv_drop", 32'(m_wv), 32'h0);
        wv = '0;
        cyc();
        check("wr_ready_fall", 32'(wr_ready), 32'h0);

        // Consumer abandons its request early: ready pulses for one cycle.
        do_reset();
        rv = 4'b1000;
        cyc();
        rv = 4'b0000;
        man_rr = 1'b1; man_rdata = 8'h66;
        cyc();
        man_rr = 1'b0;
        check("drop_ready_pulse", 32'(rd_ready), 32'h8);
        check("drop_data", 32'(byte_of(rd_data, 3)), 32'h66);
        cyc();
        check("drop_ready_gone", 32'(rd_ready), 32'h0);

        // Reset while waiting on memory, then regrant the same request.
        do_reset();
        rd_addr[23:16] = 8'h3C;
        rv = 4'b0100;
        cyc();
        check("mrst_pre_rv", 32'(m_rv), 32'h1);
        reset = 1'b0;
        #1;
        check("mrst_rv_clear", 32'(m_rv), 32'h0);
        check("mrst_addr_clear", 32'(m_raddr), 32'h0);
        #2;
        reset = 1'b1;
        cyc();
        check("mrst_regrant_rv", 32'(m_rv), 32'h1);
        check("mrst_regrant_addr", 32'(m_raddr), 32'h3C);
        man_rr = 1'b1; man_rdata = 8'h99;
        cyc();
        man_rr = 1'b0;
        check("mrst_ready", 32'(rd_ready), 32'h4);
        check("mrst_data", 32'(byte_of(rd_data, 2)), 32'h99);
        rv = '0;
        cyc();

        // Two channels: consumers 1 and 3 served in the same cycle.
        do_reset();
        d2_rv = 4'b1010;
        cyc();
        check("dual_rv", 32'(d2_m_rv), 32'h3);
        check("dual_addr", 32'(d2_m_raddr), 32'h2321);
        d2_m_rr = 2'b11; d2_m_rdata = 16'hB3B1;
        cyc();
        d2_m_rr = 2'b00;
        check("dual_ready", 32'(d2_rd_ready), 32'hA);
        check("dual_data1", 32'(byte_of(d2_rd_data, 1)), 32'hB1);
        check("dual_data3", 32'(byte_of(d2_rd_data, 3)), 32'hB3);
        d2_rv = 4'b0000;
        cyc();
        check("dual_release", 32'(d2_rd_ready), 32'h0);
        d2_rv = 4'b0100;
        cyc();
        check("dual_single_owner", 32'(d2_m_rv), 32'h1);
        check("dual_single_addr", 32'(d2_m_raddr[7:0]), 32'h22);
        d2_rv = 4'b0000;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
